// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - state encoding and constants shared by the data-memory DMA engine
package dma_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam logic [31:0] WORD_STRIDE = 32'd4;
  localparam logic [31:0] IDLE_ADDR   = 32'h0000_0000;

endpackage

// File: rtl/dmem_dma.sv
// rtl/dmem_dma.sv - bus-initiator DMA engine copying or filling word blocks on the data-memory bus
// Flat FSM plus src/dst/remaining counters; bus strobes are gated by grant so no beat leaks while ungranted.
module dmem_dma
  import dma_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] IDLE_ADDR = dma_pkg::IDLE_ADDR
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      err_addr,
  output logic             irq,
  input  logic             irq_clr,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic             bus_rd,
  output logic             bus_wr,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_acc
);

  logic [2:0]       state;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      buf_q;
  logic [31:0]      fill_q;
  logic [CNT_W-1:0] rem_q;
  logic             mode_q;

  logic rd_beat;
  logic wr_beat;

  assign rd_beat = (state == ST_RD) && bus_gnt;
  assign wr_beat = (state == ST_WR) && bus_gnt;

  assign bus_req = (state == ST_REQ) || (state == ST_RD) || (state == ST_WR);
  assign bus_rd  = rd_beat;
  assign bus_wr  = wr_beat;

  // Park the bus on an unmapped address whenever no beat is in flight.
  always_comb begin
    bus_addr  = IDLE_ADDR;
    bus_wdata = 32'h0;
    if (rd_beat) begin
      bus_addr = src_q;
    end else if (wr_beat) begin
      bus_addr  = dst_q;
      bus_wdata = (mode_q == MODE_FILL) ? fill_q : buf_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      src_q    <= 32'h0;
      dst_q    <= 32'h0;
      buf_q    <= 32'h0;
      fill_q   <= 32'h0;
      rem_q    <= '0;
      mode_q   <= MODE_COPY;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_addr <= 32'h0;
      irq      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // Later assignments to irq in this block win, so a set beats a same-cycle clear.
      if (irq_clr) irq <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            rem_q  <= count;
            mode_q <= mode;
            fill_q <= fill_data;
            if (dst_addr[1:0] != 2'b00) begin
              err      <= 1'b1;
              err_addr <= dst_addr;
              irq      <= 1'b1;
            end else if ((mode == MODE_COPY) && (src_addr[1:0] != 2'b00)) begin
              err      <= 1'b1;
              err_addr <= src_addr;
              irq      <= 1'b1;
            end else if (count == '0) begin
              done <= 1'b1;
              irq  <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          if (bus_gnt) state <= (mode_q == MODE_COPY) ? ST_RD : ST_WR;
        end

        ST_RD: begin
          if (bus_gnt) begin
            if (!bus_acc) begin
              err      <= 1'b1;
              err_addr <= src_q;
              irq      <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              buf_q <= bus_rdata;
              state <= ST_WR;
            end
          end
        end

        ST_WR: begin
          if (bus_gnt) begin
            dst_q <= dst_q + WORD_STRIDE;
            if (mode_q == MODE_COPY) src_q <= src_q + WORD_STRIDE;
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              done  <= 1'b1;
              irq   <= 1'b1;
              busy  <= 1'b0;
              state <= ST_FIN;
            end else if (mode_q == MODE_COPY) begin
              state <= ST_RD;
            end
          end
        end

        ST_FIN: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dma.sv
// tb/tb_dmem_dma.sv - directed and randomized transfers against a word-memory and transfer-level model
module tb_dmem_dma;
  import dma_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [31:0]      src_addr = 32'h0;
  logic [31:0]      dst_addr = 32'h0;
  logic [CNT_W-1:0] count = '0;
  logic [31:0]      fill_data = 32'h0;
  logic             irq_clr = 1'b0;
  logic             busy, done, err, irq, bus_req, bus_rd, bus_wr, bus_gnt, bus_acc;
  logic [31:0]      err_addr, bus_addr, bus_wdata, bus_rdata;

  logic gnt_force = 1'b1;
  logic gnt_rand_en = 1'b0;
  logic gnt_rnd = 1'b1;
  logic preload_req = 1'b0;

  always #5 clk = ~clk;

  dmem_dma #(.CNT_W(CNT_W), .IDLE_ADDR(IDLE_ADDR)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .count(count), .fill_data(fill_data),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .irq(irq), .irq_clr(irq_clr),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_acc(bus_acc)
  );

  // Data memory: two 4 KiB mapped windows (data segment and top of stack).
  logic [31:0] mem [0:2047];

  function automatic logic mapped(input logic [31:0] a);
    return (a[31:12] == 20'h10010) || (a[31:12] == 20'h7ffff);
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'({(a[31:12] == 20'h7ffff), a[11:2]});
  endfunction

  function automatic logic [31:0] peek(input logic [31:0] a);
    return mapped(a) ? mem[idx(a)] : 32'h0;
  endfunction

  assign bus_acc   = mapped(bus_addr);
  assign bus_rdata = peek(bus_addr);
  assign bus_gnt   = gnt_force & gnt_rnd;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 2048; i++) mem[i] <= $urandom;
    end else if (bus_wr && mapped(bus_addr)) begin
      mem[idx(bus_addr)] <= bus_wdata;
    end
  end

  always @(posedge clk) gnt_rnd <= gnt_rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          first_req, req_cnt, done_cnt, done_cyc, err_cnt, err_cyc, rd_cnt;
  int          strobe_viol, idle_viol;
  logic [31:0] err_seen;
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_req) begin
        req_cnt++;
        if (first_req < 0) first_req = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; err_seen = err_addr; end
      if (bus_rd) rd_cnt++;
      if (bus_wr) begin wr_a.push_back(bus_addr); wr_d.push_back(bus_wdata); end
      if ((bus_rd || bus_wr) && !bus_gnt) strobe_viol++;
      if (!bus_rd && !bus_wr && (bus_addr !== IDLE_ADDR || bus_wdata !== 32'h0)) idle_viol++;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_b({tag, ":busy"}, busy, 1'b0);
    check_b({tag, ":done"}, done, 1'b0);
    check_b({tag, ":err"}, err, 1'b0);
    check_b({tag, ":irq"}, irq, 1'b0);
    check({tag, ":err_addr"}, err_addr, 32'h0);
    check_b({tag, ":bus_req"}, bus_req, 1'b0);
    check_b({tag, ":bus_rd"}, bus_rd, 1'b0);
    check_b({tag, ":bus_wr"}, bus_wr, 1'b0);
    check({tag, ":bus_addr"}, bus_addr, IDLE_ADDR);
    check({tag, ":bus_wdata"}, bus_wdata, 32'h0);
  endtask

  int c0;

  task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d,
                       input logic [CNT_W-1:0] n, input logic [31:0] f);
    first_req = -1; req_cnt = 0; done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    rd_cnt = 0; strobe_viol = 0; idle_viol = 0; err_seen = 32'hx;
    wr_a.delete(); wr_d.delete();
    mode = m; src_addr = s; dst_addr = d; count = n; fill_data = f; start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_b({tag, ":finished_in_budget"}, n < 300, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Transfer-level expectation: the words the destination must hold afterwards.
  logic        x_mode;
  logic [31:0] x_dst;
  int          x_n;
  logic [31:0] exp_d[$];

  task automatic expect_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                             input int n, input logic [31:0] f);
    x_mode = m; x_dst = d; x_n = n;
    exp_d.delete();
    for (int i = 0; i < n; i++) exp_d.push_back((m == MODE_FILL) ? f : peek(s + 32'(4 * i)));
  endtask

  task automatic verify_xfer(input string tag, input bit timed, input int extra);
    wait_end(tag);
    check({tag, ":done_cnt"}, done_cnt, 1);
    check({tag, ":err_cnt"}, err_cnt, 0);
    check({tag, ":wr_beats"}, wr_a.size(), x_n);
    check({tag, ":rd_beats"}, rd_cnt, (x_mode == MODE_COPY) ? x_n : 0);
    for (int i = 0; i < x_n; i++) begin
      if (i < wr_a.size()) begin
        check($sformatf("%s:wr_addr%0d", tag, i), wr_a[i], x_dst + 32'(4 * i));
        check($sformatf("%s:wr_data%0d", tag, i), wr_d[i], exp_d[i]);
      end
      check($sformatf("%s:mem%0d", tag, i), peek(x_dst + 32'(4 * i)), exp_d[i]);
    end
    if (timed) begin
      check({tag, ":first_req"}, first_req, c0 + 1);
      check({tag, ":done_latency"}, done_cyc - first_req,
            ((x_mode == MODE_COPY) ? 2 * x_n : x_n) + 1 + extra);
    end
    check_b({tag, ":busy_after"}, busy, 1'b0);
    check_b({tag, ":irq_after"}, irq, 1'b1);
    check({tag, ":strobe_ungranted"}, strobe_viol, 0);
    check({tag, ":idle_bus"}, idle_viol, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    preload_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    preload_req = 1'b0;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Copy 3 words from data segment to top of stack.
    expect_xfer(MODE_COPY, 32'h1001_0000, 32'h7fff_ff80, 3, 32'h0);
    issue(MODE_COPY, 32'h1001_0000, 32'h7fff_ff80, 16'd3, 32'h0);
    verify_xfer("copy3", 1'b1, 0);

    // Fill 4 words.
    expect_xfer(MODE_FILL, 32'h0, 32'h1001_0010, 4, 32'hDEAD_BEEF);
    issue(MODE_FILL, 32'h0, 32'h1001_0010, 16'd4, 32'hDEAD_BEEF);
    verify_xfer("fill4", 1'b1, 0);

    // Unmapped source: read fault on the first beat, nothing written.
    issue(MODE_COPY, 32'h0000_1000, 32'h7fff_f800, 16'd2, 32'h0);
    wait_end("rdfault");
    check("rdfault:err_cnt", err_cnt, 1);
    check("rdfault:done_cnt", done_cnt, 0);
    check("rdfault:err_addr", err_seen, 32'h0000_1000);
    check("rdfault:err_cyc", err_cyc, c0 + 3);
    check("rdfault:wr_beats", wr_a.size(), 0);
    check_b("rdfault:busy", busy, 1'b0);

    // Misaligned destination wins over misaligned source.
    issue(MODE_COPY, 32'h1001_0001, 32'h1001_0002, 16'd4, 32'h0);
    wait_end("misdst");
    check("misdst:err_addr", err_seen, 32'h1001_0002);
    check("misdst:err_cyc", err_cyc, c0 + 1);
    check("misdst:req_cycles", req_cnt, 0);

    issue(MODE_COPY, 32'h1001_0006, 32'h7fff_f000, 16'd1, 32'h0);
    wait_end("missrc");
    check("missrc:err_addr", err_seen, 32'h1001_0006);
    check("missrc:req_cycles", req_cnt, 0);

    // Zero count completes immediately without touching the bus.
    issue(MODE_FILL, 32'h0, 32'h1001_0020, 16'd0, 32'h1234_5678);
    wait_end("cnt0");
    check("cnt0:done_cyc", done_cyc, c0 + 1);
    check("cnt0:err_cnt", err_cnt, 0);
    check("cnt0:req_cycles", req_cnt, 0);
    check("cnt0:wr_beats", wr_a.size(), 0);

    // Fill ignores a misaligned source address.
    expect_xfer(MODE_FILL, 32'h3, 32'h7fff_f100, 2, 32'hA5A5_0F0F);
    issue(MODE_FILL, 32'h3, 32'h7fff_f100, 16'd2, 32'hA5A5_0F0F);
    verify_xfer("fill_oddsrc", 1'b1, 0);

    // Grant withdrawn for three cycles during the first write beat.
    expect_xfer(MODE_COPY, 32'h1001_0100, 32'h7fff_f400, 2, 32'h0);
    issue(MODE_COPY, 32'h1001_0100, 32'h7fff_f400, 16'd2, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    gnt_force = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_b($sformatf("nognt:rd%0d", k), bus_rd, 1'b0);
      check_b($sformatf("nognt:wr%0d", k), bus_wr, 1'b0);
      check_b($sformatf("nognt:req%0d", k), bus_req, 1'b1);
    end
    @(posedge clk); #1;
    gnt_force = 1'b1;
    verify_xfer("gntdrop", 1'b1, 3);

    // Randomized transfers, every other one under a jittering grant.
    for (int r = 0; r < 6; r++) begin
      logic        rm;
      int          rn;
      logic [31:0] rs, rd, rf;
      gnt_rand_en = r[0];
      @(posedge clk); #1;
      rm = 1'($urandom_range(0, 1));
      rn = $urandom_range(1, 8);
      rs = 32'h1001_0000 + 32'(4 * $urandom_range(0, 200));
      rd = 32'h7fff_f000 + 32'(4 * $urandom_range(0, 200));
      rf = $urandom;
      expect_xfer(rm, rs, rd, rn, rf);
      issue(rm, rs, rd, CNT_W'(rn), rf);
      verify_xfer($sformatf("rand%0d", r), !r[0], 0);
    end
    gnt_rand_en = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a copy.
    issue(MODE_COPY, 32'h1001_0200, 32'h7fff_f600, 16'd3, 32'h0);
    begin
      int n = 0;
      while (wr_a.size() < 1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check_b("midrst:first_word", n < 100, 1'b1);
    end
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    check("midrst:done_cnt", done_cnt, 0);
    check("midrst:err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    expect_xfer(MODE_FILL, 32'h0, 32'h1001_0300, 3, 32'h0BAD_F00D);
    issue(MODE_FILL, 32'h0, 32'h1001_0300, 16'd3, 32'h0BAD_F00D);
    verify_xfer("after_rst", 1'b1, 0);

    // A clear arriving at the same edge as done must not win.
    irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;
    check_b("irqclr:cleared", irq, 1'b0);
    issue(MODE_FILL, 32'h0, 32'h1001_0400, 16'd1, 32'h5555_AAAA);
    @(posedge clk); #1;
    irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;
    check_b("irqclr:done_now", done, 1'b1);
    check_b("irqclr:set_wins", irq, 1'b1);
    @(posedge clk); #1;
    irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;
    check_b("irqclr:clear_alone", irq, 1'b0);
    check("irqclr:mem", peek(32'h1001_0400), 32'h5555_AAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
